// File: rtl/mem_bank_pkg.sv
// Shared types and helpers for the memory bank: FSM state encoding and byte-lane merge.
package mem_bank_pkg;

  typedef enum logic [1:0] {
    StResetClr,
    StIdle,
    StClr
  } state_e;

  function automatic int unsigned be_w(input int unsigned data_w);
    return data_w / 8;
  endfunction

  function automatic logic [7:0] byte_merge(input logic [7:0] old_b,
                                            input logic [7:0] new_b,
                                            input logic       be);
    return be ? new_b : old_b;
  endfunction

endpackage

// File: rtl/mem_bank_array.sv
// Storage array: byte-enable synchronous write and registered synchronous read.
// Contents and read register are intentionally not reset.
module mem_bank_array
  import mem_bank_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 65536,
  parameter int unsigned IDX_W  = 16
) (
  input  logic                i_clk,
  input  logic                i_we,
  input  logic                i_re,
  input  logic [IDX_W-1:0]    i_addr,
  input  logic [DATA_W/8-1:0] i_be,
  input  logic [DATA_W-1:0]   i_wdata,
  output logic [DATA_W-1:0]   o_rdata
);

  localparam int unsigned BeW = be_w(DATA_W);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_rdata;
  logic [DATA_W-1:0] w_old;
  logic [DATA_W-1:0] w_merged;

  assign w_old = r_mem[i_addr];

  always_comb begin
    w_merged = w_old;
    for (int i = 0; i < BeW; i++) begin
      w_merged[8*i +: 8] = byte_merge(w_old[8*i +: 8], i_wdata[8*i +: 8], i_be[i]);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_addr] <= w_merged;
    end
    if (i_re) begin
      r_rdata <= r_mem[i_addr];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/mem_bank_rw.sv
// Memory bank top: clear-engine FSM, request/response handshake and response register
// around a byte-enable storage array.
module mem_bank_rw
  import mem_bank_pkg::*;
#(
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned ADDR_W         = 16,
  parameter int unsigned DEPTH          = 65536,
  parameter bit          CLEAR_ON_RESET = 1'b1
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_req_valid,
  output logic                o_req_ready,
  input  logic                i_req_we,
  input  logic [ADDR_W-1:0]   i_req_addr,
  input  logic [DATA_W/8-1:0] i_req_be,
  input  logic [DATA_W-1:0]   i_req_wdata,
  input  logic                i_clr_req,
  output logic                o_busy,
  output logic                o_rsp_valid,
  input  logic                i_rsp_ready,
  output logic [DATA_W-1:0]   o_rsp_rdata,
  output logic                o_rsp_err
);

  localparam int unsigned BeW      = be_w(DATA_W);
  localparam int unsigned IdxW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(DEPTH - 1);
  localparam state_e      RstState = CLEAR_ON_RESET ? StResetClr : StIdle;

  state_e            r_state;
  state_e            w_state_next;
  logic [IdxW-1:0]   r_clr_ptr;
  logic [IdxW-1:0]   w_clr_ptr_next;
  logic              r_rsp_valid;
  logic              r_rsp_err;

  logic              w_clearing;
  logic              w_accept;
  logic              w_in_range;
  logic              w_arr_we;
  logic              w_arr_re;
  logic [IdxW-1:0]   w_arr_addr;
  logic [BeW-1:0]    w_arr_be;
  logic [DATA_W-1:0] w_arr_wdata;
  logic [DATA_W-1:0] w_arr_rdata;

  assign w_clearing  = (r_state != StIdle);
  assign w_in_range  = 32'(i_req_addr) < DEPTH;
  // Held low during reset even when the bank resets straight into idle.
  assign o_req_ready = i_rst_n && !w_clearing && (!r_rsp_valid || i_rsp_ready);
  assign w_accept    = i_req_valid && o_req_ready;
  assign o_busy      = w_clearing;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= RstState;
      r_clr_ptr <= '0;
    end else begin
      r_state   <= w_state_next;
      r_clr_ptr <= w_clr_ptr_next;
    end
  end

  always_comb begin
    w_state_next   = r_state;
    w_clr_ptr_next = r_clr_ptr;
    unique case (r_state)
      StResetClr, StClr: begin
        w_clr_ptr_next = r_clr_ptr + 1'b1;
        if (r_clr_ptr == LastIdx) begin
          w_state_next   = StIdle;
          w_clr_ptr_next = '0;
        end
      end
      StIdle: begin
        if (i_clr_req) begin
          w_state_next   = StClr;
          w_clr_ptr_next = '0;
        end
      end
      default: w_state_next = StIdle;
    endcase
  end

  // The clear engine owns the single array port whenever it runs; no requests are accepted then.
  always_comb begin
    w_arr_we    = w_clearing || (w_accept && i_req_we && w_in_range);
    w_arr_re    = w_accept && !i_req_we && w_in_range;
    w_arr_addr  = w_clearing ? r_clr_ptr : i_req_addr[IdxW-1:0];
    w_arr_be    = w_clearing ? '1 : i_req_be;
    w_arr_wdata = w_clearing ? '0 : i_req_wdata;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rsp_valid <= 1'b0;
      r_rsp_err   <= 1'b0;
    end else if (w_accept && !i_req_we) begin
      r_rsp_valid <= 1'b1;
      r_rsp_err   <= !w_in_range;
    end else if (i_rsp_ready) begin
      r_rsp_valid <= 1'b0;
      r_rsp_err   <= 1'b0;
    end
  end

  mem_bank_array #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .IDX_W  (IdxW)
  ) u_array (
    .i_clk   (i_clk),
    .i_we    (w_arr_we),
    .i_re    (w_arr_re),
    .i_addr  (w_arr_addr),
    .i_be    (w_arr_be),
    .i_wdata (w_arr_wdata),
    .o_rdata (w_arr_rdata)
  );

  // Array read register is not reset, so data is masked to zero outside a valid in-range response.
  assign o_rsp_valid = r_rsp_valid;
  assign o_rsp_err   = r_rsp_err;
  assign o_rsp_rdata = (r_rsp_valid && !r_rsp_err) ? w_arr_rdata : '0;

endmodule

// File: tb/tb_mem_bank_rw.sv
// Scoreboard bench for mem_bank_rw: a word-array reference model predicts read responses,
// and an independent monitor compares them as the DUT presents them.
module tb_mem_bank_rw;

  localparam int unsigned DW    = 32;
  localparam int unsigned AW    = 5;
  localparam int unsigned DEPTH = 12;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_we = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [3:0]    req_be = '0;
  logic [DW-1:0] req_wdata = '0;
  logic          clr_req = 1'b0;
  logic          busy;
  logic          rsp_valid;
  logic          rsp_ready = 1'b1;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_err;

  always #5 clk = ~clk;

  mem_bank_rw #(
    .DATA_W         (DW),
    .ADDR_W         (AW),
    .DEPTH          (DEPTH),
    .CLEAR_ON_RESET (1'b1)
  ) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_req_valid (req_valid),
    .o_req_ready (req_ready),
    .i_req_we    (req_we),
    .i_req_addr  (req_addr),
    .i_req_be    (req_be),
    .i_req_wdata (req_wdata),
    .i_clr_req   (clr_req),
    .o_busy      (busy),
    .o_rsp_valid (rsp_valid),
    .i_rsp_ready (rsp_ready),
    .o_rsp_rdata (rsp_rdata),
    .o_rsp_err   (rsp_err)
  );

  typedef struct packed {
    logic [31:0] data;
    logic        err;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        mon_e;
  logic [31:0] model [DEPTH];
  int          n_vec = 0;
  int          n_fail = 0;
  int          rdy_mode = 0;  // 0: always ready, 1: random, 2: driven by main sequence

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rdy_mode == 0) rsp_ready = 1'b1;
      else if (rdy_mode == 1) rsp_ready = ($urandom_range(0, 3) != 0);
    end
  end

  // Monitor: pops the expected response whenever one is consumed, checks hold stability.
  logic        prev_stall = 1'b0;
  logic [31:0] prev_data;
  logic        prev_err;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("rsp_hold_valid", 32'(rsp_valid), 32'd1);
        check("rsp_hold_data", rsp_rdata, prev_data);
        check("rsp_hold_err", 32'(rsp_err), 32'(prev_err));
      end
      if (rsp_valid && !rsp_ready) check("req_ready_while_stalled", 32'(req_ready), 32'd0);
      if (rsp_valid && rsp_ready) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_fail++;
          $display("FAIL rsp_unexpected: got data %h err %b, expected no response", rsp_rdata,
                   rsp_err);
        end else begin
          mon_e = exp_q.pop_front();
          check("rsp_rdata", rsp_rdata, mon_e.data);
          check("rsp_err", 32'(rsp_err), 32'(mon_e.err));
        end
      end
      prev_stall = rsp_valid && !rsp_ready;
      prev_data  = rsp_rdata;
      prev_err   = rsp_err;
    end
  end

  // Call only at posedge+1: inputs set now, acceptance seen on the following negedge.
  task automatic do_req(input logic we, input logic [AW-1:0] addr, input logic [3:0] be,
                        input logic [31:0] wd, input logic clr);
    int   w = 0;
    exp_t e;
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_be    = be;
    req_wdata = wd;
    @(negedge clk);
    while (!req_ready && w < 200) begin
      @(negedge clk);
      w++;
    end
    if (!req_ready) begin
      n_vec++;
      n_fail++;
      $display("FAIL req_timeout: req_ready 0 after %0d cycles, expected 1", w);
      req_valid = 1'b0;
      return;
    end
    clr_req = clr;
    if (we) begin
      if (addr < DEPTH) begin
        for (int b = 0; b < 4; b++) begin
          if (be[b]) model[addr][8*b +: 8] = wd[8*b +: 8];
        end
      end
    end else begin
      if (addr < DEPTH) begin
        e.data = model[addr];
        e.err  = 1'b0;
      end else begin
        e.data = '0;
        e.err  = 1'b1;
      end
      exp_q.push_back(e);
    end
    if (clr) begin
      for (int i = 0; i < DEPTH; i++) model[i] = '0;
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    clr_req   = 1'b0;
  endtask

  task automatic count_busy(input string name);
    int n    = 0;
    bit done = 1'b0;
    for (int i = 0; i < DEPTH + 20 && !done; i++) begin
      @(negedge clk);
      if (busy) begin
        n++;
        check("req_ready_while_busy", 32'(req_ready), 32'd0);
      end else begin
        done = 1'b1;
      end
    end
    check(name, n, DEPTH);
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int w = 0;
    while (exp_q.size() != 0 && w < 500) begin
      @(posedge clk);
      w++;
    end
    if (exp_q.size() != 0) begin
      n_vec++;
      n_fail++;
      $display("FAIL drain_timeout: %0d responses outstanding, expected 0", exp_q.size());
      exp_q.delete();
    end
    @(posedge clk);
    #1;
  endtask

  task automatic read_all();
    for (int a = 0; a < DEPTH; a++) do_req(1'b0, AW'(a), 4'h0, 32'h0, 1'b0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("reset_req_ready", 32'(req_ready), 32'd0);
    check("reset_busy", 32'(busy), 32'd1);
    check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    check("reset_rsp_rdata", rsp_rdata, 32'd0);
    check("reset_rsp_err", 32'(rsp_err), 32'd0);
    rst_n = 1'b1;
    for (int i = 0; i < DEPTH; i++) model[i] = '0;
    count_busy("reset_clear_cycles");
    read_all();

    do_req(1'b1, 5'd0, 4'hF, 32'h12345678, 1'b0);
    do_req(1'b1, 5'd1, 4'hF, 32'h87654321, 1'b0);
    do_req(1'b1, 5'd2, 4'hF, 32'hdeadbeef, 1'b0);
    do_req(1'b0, 5'd0, 4'h0, 32'h0, 1'b0);
    do_req(1'b0, 5'd1, 4'h0, 32'h0, 1'b0);
    do_req(1'b0, 5'd2, 4'h0, 32'h0, 1'b0);

    do_req(1'b1, 5'd5, 4'hF, 32'hAABBCCDD, 1'b0);
    do_req(1'b1, 5'd5, 4'b0101, 32'h11223344, 1'b0);
    do_req(1'b1, 5'd5, 4'h0, 32'h99999999, 1'b0);
    do_req(1'b0, 5'd5, 4'h0, 32'h0, 1'b0);
    drain();

    // Back-pressure: read 3 held for four cycles while a read of 4 waits.
    rdy_mode  = 2;
    rsp_ready = 1'b0;
    do_req(1'b1, 5'd3, 4'hF, 32'hC0FFEE03, 1'b0);
    do_req(1'b0, 5'd3, 4'h0, 32'h0, 1'b0);
    req_valid = 1'b1;
    req_we    = 1'b0;
    req_addr  = 5'd4;
    repeat (4) begin
      @(negedge clk);
      check("stall_req_ready", 32'(req_ready), 32'd0);
      check("stall_rsp_valid", 32'(rsp_valid), 32'd1);
    end
    @(posedge clk);
    #1;
    rsp_ready = 1'b1;
    @(negedge clk);
    check("ready_rise_accept", 32'(req_ready), 32'd1);
    exp_q.push_back('{data: model[4], err: 1'b0});
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    rdy_mode  = 0;
    drain();

    // Out-of-range accesses, plus both sides of the DEPTH boundary.
    do_req(1'b1, 5'd13, 4'hF, 32'hFFFFFFFF, 1'b0);
    do_req(1'b1, 5'd12, 4'hF, 32'hFFFFFFFF, 1'b0);
    do_req(1'b1, 5'd11, 4'hF, 32'h0B0B0B0B, 1'b0);
    do_req(1'b0, 5'd13, 4'h0, 32'h0, 1'b0);
    do_req(1'b0, 5'd12, 4'h0, 32'h0, 1'b0);
    do_req(1'b0, 5'd31, 4'h0, 32'h0, 1'b0);
    do_req(1'b0, 5'd11, 4'h0, 32'h0, 1'b0);
    read_all();
    drain();

    rdy_mode = 1;
    repeat (300) begin
      do_req(1'($urandom_range(0, 1)), 5'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
             $urandom, 1'b0);
      if ($urandom_range(0, 7) == 0) begin
        @(posedge clk);
        #1;
      end
    end
    drain();
    rdy_mode = 0;
    @(posedge clk);
    #1;

    // Clear alongside a read: the read still returns the pre-clear word.
    do_req(1'b1, 5'd2, 4'hF, 32'hdeadbeef, 1'b0);
    do_req(1'b0, 5'd2, 4'h0, 32'h0, 1'b1);
    count_busy("clr_cycles");
    read_all();
    drain();

    for (int a = 0; a < DEPTH; a++) do_req(1'b1, AW'(a), 4'hF, $urandom | 32'h1, 1'b0);
    clr_req = 1'b1;
    @(posedge clk);
    #1;
    clr_req = 1'b0;
    for (int i = 0; i < DEPTH; i++) model[i] = '0;
    repeat (5) @(posedge clk);
    #1;
    rst_n = 1'b0;
    exp_q.delete();
    @(posedge clk);
    #1;
    check("mid_clear_reset_busy", 32'(busy), 32'd1);
    check("mid_clear_reset_req_ready", 32'(req_ready), 32'd0);
    rst_n = 1'b1;
    count_busy("reset_mid_clear_cycles");
    read_all();
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_bank_rw.md
# mem_bank_rw

Parametrised single-port memory bank with byte-enable writes, a one-cycle registered read behind a valid/ready handshake, and a hardware clear engine. Successor to the fixed 32x16 memory: generalised width and depth, back-pressured read responses, partial writes, and deterministic zero-initialisation. Sits between an on-chip master (CPU/DMA port) and local storage; one instance per bank.

## Interface
- DATA_W, 32, data width in bits; must be a multiple of 8
- ADDR_W, 16, address width in bits
- DEPTH, 65536, number of words; must be ≤ 2**ADDR_W
- CLEAR_ON_RESET, 1, 1 = zero every word automatically after reset release
- clk  in  1  clock; all logic on the rising edge
- rst  in  1  asynchronous, active-low reset
- req_valid  in  1  request present
- req_ready  out  1  bank can accept a request this cycle
- req_we  in  1  1 = write, 0 = read
- req_addr  in  ADDR_W  word address
- req_be  in  DATA_W/8  byte enables (writes only; bit i covers bits 8i+7:8i)
- req_wdata  in  DATA_W  write data
- clr_req  in  1  single-cycle pulse: zero the whole bank
- busy  out  1  clear engine running
- rsp_valid  out  1  read data valid
- rsp_ready  in  1  consumer accepts read data
- rsp_rdata  out  DATA_W  read data
- rsp_err  out  1  response belongs to an out-of-range read; qualified by rsp_valid

## Operation
- FSM states: RESET_CLR, IDLE, CLR. On rst low: state = RESET_CLR if CLEAR_ON_RESET else IDLE; clear pointer = 0.
- RESET_CLR / CLR: one word per cycle written to zero at the clear pointer, pointer increments; after word DEPTH-1 go to IDLE. busy = 1, req_ready = 0 throughout.
- IDLE + clr_req: go to CLR next cycle, pointer = 0. clr_req ignored in RESET_CLR/CLR.
- req_ready = (state == IDLE) && (!rsp_valid || rsp_ready).
- Accept = req_valid && req_ready. Write accept: bytes with req_be set updated at that edge, others keep old value; no response. req_be = 0 is a legal no-op write.
- Read accept: rsp_valid = 1 next cycle with rsp_rdata = stored word; held stable until rsp_valid && rsp_ready.
- Out-of-range (req_addr ≥ DEPTH): write dropped; read returns rsp_rdata = 0, rsp_err = 1.
- Simultaneous accept and clr_req: request completes first (read response still delivered), clear starts next cycle.
- Outstanding read response when clear starts: stays valid and unchanged until consumed.
- rst low at any point (including mid-clear): outputs to reset values, clear restarts from word 0.

## Timing
- Reset values: req_ready 0, busy = CLEAR_ON_RESET, rsp_valid 0, rsp_rdata 0, rsp_err 0.
- Read latency: 1 cycle from accept to rsp_valid.
- Full throughput: one accept per cycle while rsp_ready is held high.
- Clear duration: exactly DEPTH cycles; busy falls, req_ready may rise, on cycle DEPTH after entering the clear state.
- Write then read of the same address in consecutive cycles returns the new data.

## Structure
- Package mem_bank_pkg: state enum (RESET_CLR, IDLE, CLR), function byte-merge (old, new, be), BE_W = DATA_W/8 helper.
- Sub-module mem_bank_array: storage array, byte-enable synchronous write, synchronous read; no reset on contents. Top holds FSM, clear pointer, handshake and response register.

## Test plan
- Reset release with DEPTH=16, CLEAR_ON_RESET=1 -> busy high exactly 16 cycles, then read of every address returns 0x00000000.
- Write 0x12345678 @0, 0x87654321 @1, 0xdeadbeef @2 (be=4'hF), then read 0,1,2 -> same values, each 1 cycle after accept.
- Write 0xAABBCCDD @5 be=4'hF, then 0x11223344 @5 be=4'b0101 -> read 5 gives 0xAA22CC44.
- Read @3 with rsp_ready low for 4 cycles -> rsp_valid/rsp_rdata stable, req_ready low; next request accepted the cycle rsp_ready rises.
- DEPTH=12, write 0xFFFFFFFF @13, read @13 -> rsp_rdata 0, rsp_err 1; array unchanged.
- clr_req in same cycle as read @2 (holding 0xdeadbeef) -> response 0xdeadbeef delivered, then busy for DEPTH cycles; rst pulsed low mid-clear -> clear restarts at word 0, all words read 0 afterwards.
